// File: rtl/inst_sram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_sram_axi_bridge_pkg
// Brief    : Shared AXI constants, AR FSM encoding and default fetch ARID
//            for the instruction SRAM-to-AXI bridge.
// Revision : 1.0 - initial release
// ============================================================================
package inst_sram_axi_bridge_pkg;

    // AXI encodings used by a single-beat word read
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // AR channel FSM encoding
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    // Default AXI ID used for all instruction-side reads
    localparam logic [3:0] INST_ARID = 4'd0;

endpackage : inst_sram_axi_bridge_pkg
`default_nettype wire

// File: rtl/inst_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : inst_sram_axi_bridge
// Brief    : Converts the fetch stage's SRAM-like req/addr_ok/data_ok port
//            into an AXI4 read-only master with a bounded number of
//            in-flight single-beat reads. Data returns in request order.
// Revision : 1.0 - initial release
// ============================================================================
module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0]  ARID            = INST_ARID,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    // SRAM-like fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  axi_arid,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // Status
    output logic        rresp_err
);

    // The counter is 2 bits wide, enough for the supported range 1..3
    localparam logic [1:0] C_MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [0:0]  r_ar_state_q;
    logic [0:0]  w_ar_state_d;
    logic [31:0] r_araddr_q;
    logic [31:0] w_araddr_d;
    logic [1:0]  r_cnt_q;
    logic [1:0]  w_cnt_d;
    logic        r_data_ok_q;
    logic        w_data_ok_d;
    logic [31:0] r_rdata_q;
    logic [31:0] w_rdata_d;
    logic        r_rresp_err_q;
    logic        w_rresp_err_d;

    logic        w_accept;
    logic        w_own_beat;
    logic        w_ret;
    logic        w_unused;

    // Fetches are always word reads; write-side inputs carry no information
    assign w_unused = ^{inst_sram_size, inst_sram_wstrb, inst_sram_wdata};

    // Fixed AR attributes; the ID is a constant so the fetch stage can match it
    assign arid     = ARID;
    assign axi_arid = ARID;
    assign arlen    = AXI_LEN_SINGLE;
    assign arsize   = AXI_SIZE_WORD;
    assign arburst  = AXI_BURST_INCR;
    assign araddr   = r_araddr_q;
    assign arvalid  = (r_ar_state_q == AR_SEND);

    // R channel is always drained outside reset; foreign IDs are simply dropped
    assign rready   = ~reset;

    // Accept only reads, only when idle, and only while below the in-flight cap
    assign inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr
                             & (r_ar_state_q == AR_IDLE)
                             & (r_cnt_q < C_MAX_OUT);
    assign w_accept   = inst_sram_req & inst_sram_addr_ok;

    // A beat only retires a fetch if one is actually outstanding
    assign w_own_beat = rvalid & rready & (rid == ARID) & rlast;
    assign w_ret      = w_own_beat & (r_cnt_q != 2'd0);

    assign inst_sram_data_ok = r_data_ok_q;
    assign inst_sram_rdata   = r_rdata_q;
    assign rresp_err         = r_rresp_err_q;

    // AR FSM: latch address on accept, hold it on the bus until arready
    always_comb begin
        w_ar_state_d = r_ar_state_q;
        w_araddr_d   = r_araddr_q;
        case (r_ar_state_q)
            AR_IDLE: begin
                if (w_accept) begin
                    w_araddr_d   = inst_sram_addr;
                    w_ar_state_d = AR_SEND;
                end
            end
            AR_SEND: begin
                if (arready) begin
                    w_ar_state_d = AR_IDLE;
                end
            end
            default: w_ar_state_d = AR_IDLE;
        endcase
    end

    // Outstanding counter: accept and retire in one cycle cancel out
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_accept && !w_ret) begin
            w_cnt_d = r_cnt_q + 2'd1;
        end else if (!w_accept && w_ret) begin
            w_cnt_d = r_cnt_q - 2'd1;
        end
    end

    // Return path: one-cycle registered data with a single data_ok pulse
    always_comb begin
        w_data_ok_d   = w_ret;
        w_rdata_d     = w_ret ? rdata : r_rdata_q;
        w_rresp_err_d = r_rresp_err_q | (w_ret & (rresp != AXI_RESP_OKAY));
    end

    // State registers; reset discards all in-flight bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_state_q  <= AR_IDLE;
            r_araddr_q    <= 32'd0;
            r_cnt_q       <= 2'd0;
            r_data_ok_q   <= 1'b0;
            r_rdata_q     <= 32'd0;
            r_rresp_err_q <= 1'b0;
        end else begin
            r_ar_state_q  <= w_ar_state_d;
            r_araddr_q    <= w_araddr_d;
            r_cnt_q       <= w_cnt_d;
            r_data_ok_q   <= w_data_ok_d;
            r_rdata_q     <= w_rdata_d;
            r_rresp_err_q <= w_rresp_err_d;
        end
    end

endmodule : inst_sram_axi_bridge
`default_nettype wire

// File: tb/tb_inst_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_sram_axi_bridge
// Brief    : Directed self-checking bench for inst_sram_axi_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_sram_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  axi_arid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rresp_err;

    int n_vec = 0;
    int n_err = 0;

    inst_sram_axi_bridge #(
        .ARID            (4'd0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .axi_arid          (axi_arid),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready),
        .rresp_err         (rresp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rresp  = resp;
        rlast  = 1'b1;
    endtask

    // Watchdog: the stimulus is fixed-length, so this only fires on a hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'b10;
        inst_sram_wstrb = 4'h0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        check_eq("rst_arvalid",   32'(arvalid), 32'd0);
        check_eq("rst_araddr",    araddr, 32'd0);
        check_eq("rst_cnt",       32'(dut.r_cnt_q), 32'd0);
        check_eq("rst_data_ok",   32'(inst_sram_data_ok), 32'd0);
        check_eq("rst_rdata",     inst_sram_rdata, 32'd0);
        check_eq("rst_rresp_err", 32'(rresp_err), 32'd0);
        check_eq("rst_rready",    32'(rready), 32'd0);
        tick(); reset = 1'b0; #1;
        check_eq("rready_run", 32'(rready), 32'd1);
        check_eq("ar_attrs", {4'd0, axi_arid, arid, arlen, 5'd0, arsize, 6'd0, arburst},
                 {4'd0, 4'd0, 4'd0, 8'd0, 5'd0, 3'b010, 6'd0, 2'b01});

        // ---------------- single fetch ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; arready = 1'b1; #1;
        check_eq("t1_addr_ok_c0", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; #1;
        check_eq("t1_arvalid_c1", 32'(arvalid), 32'd1);
        check_eq("t1_araddr_c1",  araddr, 32'h1C00_0000);
        check_eq("t1_cnt_c1",     32'(dut.r_cnt_q), 32'd1);
        tick(); beat(4'd0, 32'h0280_0C0C, 2'b00); #1;
        check_eq("t1_arvalid_c2", 32'(arvalid), 32'd0);
        check_eq("t1_data_ok_c2", 32'(inst_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0; #1;
        check_eq("t1_data_ok_c3", 32'(inst_sram_data_ok), 32'd1);
        check_eq("t1_rdata_c3",   inst_sram_rdata, 32'h0280_0C0C);
        check_eq("t1_cnt_c3",     32'(dut.r_cnt_q), 32'd0);
        tick(); #1;
        check_eq("t1_data_ok_c4", 32'(inst_sram_data_ok), 32'd0);
        check_eq("t1_rdata_hold", inst_sram_rdata, 32'h0280_0C0C);

        // ---------------- AR back-pressure ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; arready = 1'b0; #1;
        check_eq("t2_addr_ok_c0", 32'(inst_sram_addr_ok), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick(); inst_sram_addr = 32'h1C00_0014; #1;
            check_eq($sformatf("t2_arvalid_c%0d", i), 32'(arvalid), 32'd1);
            check_eq($sformatf("t2_araddr_c%0d", i),  araddr, 32'h1C00_0010);
            check_eq($sformatf("t2_addr_ok_c%0d", i), 32'(inst_sram_addr_ok), 32'd0);
        end
        tick(); inst_sram_req = 1'b0; arready = 1'b1; #1;
        check_eq("t2_arvalid_c6", 32'(arvalid), 32'd1);
        check_eq("t2_addr_ok_c6", 32'(inst_sram_addr_ok), 32'd0);
        tick(); beat(4'd0, 32'hAAAA_0001, 2'b00); #1;
        check_eq("t2_arvalid_c7", 32'(arvalid), 32'd0);
        check_eq("t2_cnt_c7",     32'(dut.r_cnt_q), 32'd1);
        tick(); rvalid = 1'b0; #1;
        check_eq("t2_data_ok", 32'(inst_sram_data_ok), 32'd1);
        check_eq("t2_rdata",   inst_sram_rdata, 32'hAAAA_0001);
        check_eq("t2_cnt_end", 32'(dut.r_cnt_q), 32'd0);

        // ---------------- outstanding limit ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0100; #1;
        check_eq("t3_addr_ok_a", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; #1;
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0104; #1;
        check_eq("t3_addr_ok_b", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; #1;
        check_eq("t3_araddr_b", araddr, 32'h0000_0104);
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0108; #1;
        check_eq("t3_addr_ok_c_full", 32'(inst_sram_addr_ok), 32'd0);
        check_eq("t3_cnt_full",       32'(dut.r_cnt_q), 32'd2);
        tick(); #1;
        check_eq("t3_addr_ok_c_full2", 32'(inst_sram_addr_ok), 32'd0);
        tick(); beat(4'd0, 32'hD000_0001, 2'b00); #1;
        check_eq("t3_addr_ok_beat", 32'(inst_sram_addr_ok), 32'd0);
        check_eq("t3_cnt_beat",     32'(dut.r_cnt_q), 32'd2);
        tick(); rvalid = 1'b0; #1;
        check_eq("t3_cnt_after1",  32'(dut.r_cnt_q), 32'd1);
        check_eq("t3_addr_ok_c",   32'(inst_sram_addr_ok), 32'd1);
        check_eq("t3_data_ok_1",   32'(inst_sram_data_ok), 32'd1);
        check_eq("t3_rdata_1",     inst_sram_rdata, 32'hD000_0001);
        tick(); inst_sram_req = 1'b0; #1;
        check_eq("t3_araddr_c", araddr, 32'h0000_0108);
        check_eq("t3_cnt_refill", 32'(dut.r_cnt_q), 32'd2);
        tick(); beat(4'd0, 32'hD000_0002, 2'b00); #1;
        tick(); beat(4'd0, 32'hD000_0003, 2'b00); #1;
        check_eq("t3_rdata_2", inst_sram_rdata, 32'hD000_0002);
        tick(); rvalid = 1'b0; #1;
        check_eq("t3_rdata_3", inst_sram_rdata, 32'hD000_0003);
        check_eq("t3_cnt_end", 32'(dut.r_cnt_q), 32'd0);

        // ---------------- foreign ID and error response ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0200; #1;
        tick(); inst_sram_req = 1'b0; #1;
        tick(); beat(4'd1, 32'hDEAD_BEEF, 2'b00); #1;
        tick(); beat(4'd0, 32'h1234_5678, 2'b10); #1;
        check_eq("t4_foreign_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check_eq("t4_foreign_cnt",     32'(dut.r_cnt_q), 32'd1);
        check_eq("t4_foreign_rdata",   inst_sram_rdata, 32'hD000_0003);
        tick(); rvalid = 1'b0; rresp = 2'b00; #1;
        check_eq("t4_err_data_ok", 32'(inst_sram_data_ok), 32'd1);
        check_eq("t4_err_rdata",   inst_sram_rdata, 32'h1234_5678);
        check_eq("t4_err_flag",    32'(rresp_err), 32'd1);
        check_eq("t4_err_cnt",     32'(dut.r_cnt_q), 32'd0);
        repeat (10) tick();
        check_eq("t4_err_sticky", 32'(rresp_err), 32'd1);

        // ---------------- simultaneous accept and return ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0300; #1;
        tick(); inst_sram_req = 1'b0; #1;
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0304;
        beat(4'd0, 32'h0000_0055, 2'b00); #1;
        check_eq("t5_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; rvalid = 1'b0; #1;
        check_eq("t5_cnt_same", 32'(dut.r_cnt_q), 32'd1);
        check_eq("t5_data_ok",  32'(inst_sram_data_ok), 32'd1);
        check_eq("t5_rdata",    inst_sram_rdata, 32'h0000_0055);
        check_eq("t5_araddr",   araddr, 32'h0000_0304);
        tick(); beat(4'd0, 32'h0000_0066, 2'b00); #1;
        check_eq("t5_data_ok_once", 32'(inst_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0; #1;
        check_eq("t5_rdata_2", inst_sram_rdata, 32'h0000_0066);
        check_eq("t5_cnt_end", 32'(dut.r_cnt_q), 32'd0);

        // ---------------- reset mid-transaction ----------------
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0400; #1;
        tick(); inst_sram_req = 1'b0; #1;
        tick(); inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_0404; arready = 1'b0; #1;
        tick(); inst_sram_req = 1'b0; reset = 1'b1; #1;
        check_eq("t6_pre_arvalid", 32'(arvalid), 32'd1);
        check_eq("t6_pre_cnt",     32'(dut.r_cnt_q), 32'd2);
        tick(); reset = 1'b0; beat(4'd0, 32'hBAD0_0000, 2'b00); #1;
        check_eq("t6_arvalid",   32'(arvalid), 32'd0);
        check_eq("t6_araddr",    araddr, 32'd0);
        check_eq("t6_cnt",       32'(dut.r_cnt_q), 32'd0);
        check_eq("t6_data_ok",   32'(inst_sram_data_ok), 32'd0);
        check_eq("t6_rresp_err", 32'(rresp_err), 32'd0);
        tick(); rvalid = 1'b0; #1;
        check_eq("t6_stray_data_ok", 32'(inst_sram_data_ok), 32'd0);
        check_eq("t6_stray_cnt",     32'(dut.r_cnt_q), 32'd0);

        // ---------------- write request is never accepted ----------------
        arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h0000_0500; #1;
            check_eq($sformatf("t7_wr_addr_ok_%0d", i), 32'(inst_sram_addr_ok), 32'd0);
            check_eq($sformatf("t7_wr_arvalid_%0d", i), 32'(arvalid), 32'd0);
        end
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_inst_sram_axi_bridge
`default_nettype wire
